// File: rtl/rv32_pipeline_pkg.sv
// rtl/rv32_pipeline_pkg.sv - shared types for the pipeline memory port arbiter
// Purpose: state and grant-source enumerations used by mem_port_arbiter.
// Contents:
//   arb_state_t : IDLE, ADDR, RESP, DONE transaction phases
//   arb_src_t   : SRC_IF (instruction fetch) or SRC_MEM (load/store)
package rv32_pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_MEM = 1'b1
  } arb_src_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory bus channel between arbiter and memory
// Purpose: groups the request and response channel of the single memory port.
// Signals:
//   bus_valid/bus_ready                 : request handshake
//   bus_addr, bus_we, bus_be, bus_wdata : request payload
//   bus_rvalid, bus_rdata               : one response per accepted request
// Modports: master (arbiter side), slave (memory side).
interface mem_port_arbiter_if;

  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - arbitrates fetch and load/store onto one memory port
// Purpose: grants the shared bus to the MEM (load/store) or IF (fetch) requester,
//   one transaction at a time, with a starvation limit protecting IF.
// Ports:
//   clk, rst_n             : clock; synchronous reset, active high (1 = reset)
//   if_req/if_addr         : fetch request, held until if_done
//   if_rdata/if_done       : fetch word, one-cycle completion pulse
//   mem_req/we/be/addr/wdata : load/store request, held until mem_done
//   mem_rdata/mem_done     : load data, one-cycle completion pulse
//   flush                  : branch taken; cancels the current or pending fetch
//   bus                    : shared memory channel (master side)
//   if_stall/mem_stall     : stall requests to the hazard unit
module mem_port_arbiter
  import rv32_pipeline_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic [31:0]         if_rdata,
  output logic                if_done,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [3:0]          mem_be,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic [31:0]         mem_rdata,
  output logic                mem_done,
  input  logic                flush,
  mem_port_arbiter_if.master  bus,
  output logic                if_stall,
  output logic                mem_stall
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t       state;
  arb_state_t       state_nxt;
  arb_src_t         src_q;
  logic             drop_q;
  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [3:0]       be_q;
  logic             grant_mem;
  logic             grant_if;

  // MEM wins unless IF is waiting and MEM has already used its consecutive quota.
  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (mem_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
          grant_mem = 1'b1;
        end else if (if_req && !flush) begin
          grant_if = 1'b1;
        end
        if (grant_mem || grant_if) begin
          state_nxt = ADDR;
        end
      end
      ADDR:    if (bus.bus_ready)  state_nxt = RESP;
      RESP:    if (bus.bus_rvalid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      src_q      <= SRC_IF;
      drop_q     <= 1'b0;
      starve_cnt <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if (grant_mem) begin
        src_q   <= SRC_MEM;
        addr_q  <= mem_addr;
        we_q    <= mem_we;
        be_q    <= mem_be;
        wdata_q <= mem_wdata;
        drop_q  <= 1'b0;
        if (if_req && (starve_cnt != STARVE_LIM)) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (grant_if) begin
        src_q      <= SRC_IF;
        addr_q     <= if_addr;
        we_q       <= 1'b0;
        be_q       <= 4'hF;
        wdata_q    <= '0;
        drop_q     <= 1'b0;
        starve_cnt <= '0;
      end

      // A flushed fetch still finishes its bus handshake; only the result is discarded.
      if ((src_q == SRC_IF) && flush && ((state == ADDR) || (state == RESP))) begin
        drop_q <= 1'b1;
      end

      // A flush landing in the same cycle as rvalid must also keep if_rdata intact.
      if ((state == RESP) && bus.bus_rvalid) begin
        if (src_q == SRC_MEM) begin
          mem_rdata <= bus.bus_rdata;
        end else if (!drop_q && !flush) begin
          if_rdata <= bus.bus_rdata;
        end
      end
    end
  end

  assign bus.bus_valid = (state == ADDR);
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  assign if_done   = (state == DONE) && (src_q == SRC_IF) && !drop_q;
  assign mem_done  = (state == DONE) && (src_q == SRC_MEM);
  assign if_stall  = if_req & ~if_done;
  assign mem_stall = mem_req & ~mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import rv32_pipeline_pkg::*;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [3:0]  mem_be = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        flush = 1'b0;
  logic        if_stall;
  logic        mem_stall;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] last_if_rdata;

  mem_port_arbiter_if bus_if ();

  always #5 clk = ~clk;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .flush     (flush),
    .bus       (bus_if),
    .if_stall  (if_stall),
    .mem_stall (mem_stall)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (bus_if.bus_valid !== 1'b1 && k < 10) begin
      step();
      k++;
    end
    n_chk++; if (bus_if.bus_valid !== 1'b1) $display("FAIL %s_grant_timeout bus_valid=%b exp=1", tag, bus_if.bus_valid); else n_pass++;
  endtask

  // Called in ADDR; leaves the bench at the negedge of the DONE cycle.
  task automatic serve(input int rdy_wait, input logic [31:0] rd);
    repeat (rdy_wait) step();
    bus_if.bus_ready = 1'b1;
    step();
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = rd;
    step();
    bus_if.bus_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    step(); step();
    n_chk++; if (bus_if.bus_valid !== 1'b0) $display("FAIL rst_bus_valid got=%b exp=0", bus_if.bus_valid); else n_pass++;
    n_chk++; if ({if_done, mem_done} !== 2'b00) $display("FAIL rst_done got=%b exp=00", {if_done, mem_done}); else n_pass++;
    n_chk++; if (if_rdata !== 32'h0) $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); else n_pass++;
    n_chk++; if (mem_rdata !== 32'h0) $display("FAIL rst_mem_rdata got=%h exp=0", mem_rdata); else n_pass++;
    n_chk++; if ({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata} !== 69'h0)
      $display("FAIL rst_bus_regs got=%h/%b/%h/%h exp=0", bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata); else n_pass++;
    rst_n = 1'b0;
    step();
  endtask

  task automatic test_if_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_chk++; if ({if_stall, bus_if.bus_valid} !== 2'b10) $display("FAIL fetch_c0 stall/valid got=%b exp=10", {if_stall, bus_if.bus_valid}); else n_pass++;
    step();
    n_chk++; if (bus_if.bus_valid !== 1'b1) $display("FAIL fetch_c1_valid got=%b exp=1", bus_if.bus_valid); else n_pass++;
    n_chk++; if ({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be} !== {32'h100, 1'b0, 4'hF})
      $display("FAIL fetch_c1_payload got=%h/%b/%h exp=100/0/f", bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be); else n_pass++;
    n_chk++; if (if_stall !== 1'b1) $display("FAIL fetch_c1_stall got=%b exp=1", if_stall); else n_pass++;
    bus_if.bus_ready = 1'b1;
    step();
    bus_if.bus_ready = 1'b0;
    n_chk++; if ({bus_if.bus_valid, if_stall, if_done} !== 3'b010) $display("FAIL fetch_c2 valid/stall/done got=%b exp=010", {bus_if.bus_valid, if_stall, if_done}); else n_pass++;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h13;
    step();
    bus_if.bus_rvalid = 1'b0;
    n_chk++; if ({if_done, if_stall} !== 2'b10) $display("FAIL fetch_c3 done/stall got=%b exp=10", {if_done, if_stall}); else n_pass++;
    n_chk++; if (if_rdata !== 32'h13) $display("FAIL fetch_c3_rdata got=%h exp=13", if_rdata); else n_pass++;
    if_req = 1'b0;
    step();
    n_chk++; if (if_done !== 1'b0) $display("FAIL fetch_c4_done_pulse got=%b exp=0", if_done); else n_pass++;
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h2000; mem_wdata = '0;
    step();
    n_chk++; if ({bus_if.bus_valid, bus_if.bus_addr} !== {1'b1, 32'h2000}) $display("FAIL prio_first valid/addr got=%b/%h exp=1/2000", bus_if.bus_valid, bus_if.bus_addr); else n_pass++;
    serve(0, 32'hA0A0_0001);
    n_chk++; if ({mem_done, if_done} !== 2'b10) $display("FAIL prio_mem_done got=%b exp=10", {mem_done, if_done}); else n_pass++;
    n_chk++; if (mem_rdata !== 32'hA0A0_0001) $display("FAIL prio_mem_rdata got=%h exp=a0a00001", mem_rdata); else n_pass++;
    mem_req = 1'b0;
    step();
    n_chk++; if (bus_if.bus_valid !== 1'b0) $display("FAIL prio_idle_valid got=%b exp=0", bus_if.bus_valid); else n_pass++;
    step();
    n_chk++; if ({bus_if.bus_valid, bus_if.bus_addr} !== {1'b1, 32'h100}) $display("FAIL prio_if_next valid/addr got=%b/%h exp=1/100", bus_if.bus_valid, bus_if.bus_addr); else n_pass++;
    serve(0, 32'h0BAD_F00D);
    n_chk++; if ({if_done, if_rdata} !== {1'b1, 32'h0BAD_F00D}) $display("FAIL prio_if_done done/rdata got=%b/%h exp=1/0badf00d", if_done, if_rdata); else n_pass++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] exp_addr;
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h3000;
    for (int g = 1; g <= STARVE_MAX + 1; g++) begin
      wait_valid("starve");
      exp_addr = (g <= STARVE_MAX) ? 32'h3000 : 32'h100;
      n_chk++; if (bus_if.bus_addr !== exp_addr) $display("FAIL starve_grant%0d addr got=%h exp=%h", g, bus_if.bus_addr, exp_addr); else n_pass++;
      serve(0, 32'(g));
      if (g == STARVE_MAX + 1) begin
        n_chk++; if ({if_done, if_rdata} !== {1'b1, 32'(g)}) $display("FAIL starve_if_done done/rdata got=%b/%h exp=1/%h", if_done, if_rdata, 32'(g)); else n_pass++;
        if_req = 1'b0; mem_req = 1'b0;
        last_if_rdata = 32'(g);
      end
    end
    step();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h200;
    wait_valid("flush");
    bus_if.bus_ready = 1'b1;
    step();
    bus_if.bus_ready = 1'b0;
    flush = 1'b1; if_req = 1'b0;
    step();
    flush = 1'b0;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h77;
    step();
    bus_if.bus_rvalid = 1'b0;
    n_chk++; if (if_done !== 1'b0) $display("FAIL flush_no_done got=%b exp=0", if_done); else n_pass++;
    n_chk++; if (if_rdata !== last_if_rdata) $display("FAIL flush_rdata_kept got=%h exp=%h", if_rdata, last_if_rdata); else n_pass++;
    step();
    if_req = 1'b1; if_addr = 32'h300;
    wait_valid("flush_next");
    n_chk++; if (bus_if.bus_addr !== 32'h300) $display("FAIL flush_next_addr got=%h exp=300", bus_if.bus_addr); else n_pass++;
    serve(0, 32'h55);
    n_chk++; if ({if_done, if_rdata} !== {1'b1, 32'h55}) $display("FAIL flush_next_done done/rdata got=%b/%h exp=1/55", if_done, if_rdata); else n_pass++;
    if_req = 1'b0;
    step();
  endtask

  task automatic test_stalled_store();
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h4000; mem_wdata = 32'hBEEF;
    wait_valid("store");
    for (int i = 0; i < 3; i++) begin
      n_chk++; if ({bus_if.bus_valid, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata} !== {1'b1, 32'h4000, 1'b1, 4'b0011, 32'hBEEF})
        $display("FAIL store_hold%0d got=%b/%h/%b/%h/%h exp=1/4000/1/3/beef", i, bus_if.bus_valid, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata); else n_pass++;
      step();
    end
    bus_if.bus_ready = 1'b1;
    step();
    bus_if.bus_ready = 1'b0;
    n_chk++; if ({mem_done, bus_if.bus_valid} !== 2'b00) $display("FAIL store_resp done/valid got=%b exp=00", {mem_done, bus_if.bus_valid}); else n_pass++;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h1234;
    step();
    bus_if.bus_rvalid = 1'b0;
    n_chk++; if ({mem_done, mem_rdata} !== {1'b1, 32'h1234}) $display("FAIL store_done done/rdata got=%b/%h exp=1/1234", mem_done, mem_rdata); else n_pass++;
    mem_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h500;
    wait_valid("rstmid");
    rst_n = 1'b1; if_req = 1'b0;
    step();
    n_chk++; if ({bus_if.bus_valid, if_done, mem_done} !== 3'b000) $display("FAIL rstmid_state valid/done got=%b exp=000", {bus_if.bus_valid, if_done, mem_done}); else n_pass++;
    n_chk++; if ({bus_if.bus_addr, if_rdata, mem_rdata} !== 96'h0) $display("FAIL rstmid_regs got=%h/%h/%h exp=0", bus_if.bus_addr, if_rdata, mem_rdata); else n_pass++;
    rst_n = 1'b0;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h99;
    step();
    bus_if.bus_rvalid = 1'b0;
    n_chk++; if ({if_done, mem_done, bus_if.bus_valid, if_rdata} !== {3'b000, 32'h0}) $display("FAIL rstmid_late_rvalid got=%b/%h exp=000/0", {if_done, mem_done, bus_if.bus_valid}, if_rdata); else n_pass++;
    step();
    n_chk++; if ({if_done, mem_done} !== 2'b00) $display("FAIL rstmid_no_pulse got=%b exp=00", {if_done, mem_done}); else n_pass++;
  endtask

  // Random requesters plus a random-latency memory; checks are the arbitration rules
  // expressed per transaction (payload, starvation quota, done pulse, returned data).
  task automatic test_random();
    int   starve = 0;
    int   completions = 0;
    int   rv_cnt = 0;
    int   rdy_cnt = 0;
    logic prev_valid = 1'b0;
    logic acc_pend = 1'b0;
    logic outstanding = 1'b0;
    logic real_rv = 1'b0;
    logic inflight_mem = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_done;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      if (bus_if.bus_valid && !prev_valid) begin
        inflight_mem = bus_if.bus_addr[16];
        if (inflight_mem) begin
          n_chk++; if ({mem_req, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata} !== {1'b1, mem_addr, mem_we, mem_be, mem_wdata})
            $display("FAIL rnd_mem_payload cyc%0d got=%h/%b/%h/%h exp=%h/%b/%h/%h", cyc, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata, mem_addr, mem_we, mem_be, mem_wdata); else n_pass++;
          if (if_req) begin
            starve++;
            n_chk++; if (starve > STARVE_MAX) $display("FAIL rnd_starve cyc%0d consecutive_mem=%0d max=%0d", cyc, starve, STARVE_MAX); else n_pass++;
          end
        end else begin
          n_chk++; if ({if_req, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be} !== {1'b1, if_addr, 1'b0, 4'hF})
            $display("FAIL rnd_if_payload cyc%0d got=%b/%h/%b/%h exp=1/%h/0/f", cyc, if_req, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, if_addr); else n_pass++;
          if (mem_req) begin
            n_chk++; if (starve != STARVE_MAX) $display("FAIL rnd_if_over_mem cyc%0d consecutive_mem=%0d exp=%0d", cyc, starve, STARVE_MAX); else n_pass++;
          end
          starve = 0;
        end
      end
      prev_valid = bus_if.bus_valid;

      if (real_rv || if_done || mem_done) begin
        exp_done = real_rv ? (inflight_mem ? 2'b01 : 2'b10) : 2'b00;
        n_chk++; if ({if_done, mem_done} !== exp_done) $display("FAIL rnd_done cyc%0d if/mem got=%b exp=%b", cyc, {if_done, mem_done}, exp_done); else n_pass++;
        if (real_rv) begin
          completions++;
          n_chk++; if ((inflight_mem ? mem_rdata : if_rdata) !== exp_rdata)
            $display("FAIL rnd_rdata cyc%0d got=%h exp=%h", cyc, inflight_mem ? mem_rdata : if_rdata, exp_rdata); else n_pass++;
        end
      end

      n_chk++; if ({if_stall, mem_stall} !== {if_req & ~if_done, mem_req & ~mem_done})
        $display("FAIL rnd_stall cyc%0d got=%b exp=%b", cyc, {if_stall, mem_stall}, {if_req & ~if_done, mem_req & ~mem_done}); else n_pass++;

      if (acc_pend) begin
        outstanding = 1'b1;
        rv_cnt = $urandom_range(0, 2);
      end
      acc_pend = 1'b0;
      real_rv = 1'b0;
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rvalid = 1'b0;
      if (outstanding) begin
        if (rv_cnt == 0) begin
          exp_rdata = $urandom;
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata = exp_rdata;
          real_rv = 1'b1;
          outstanding = 1'b0;
        end else begin
          rv_cnt--;
        end
      end else if (bus_if.bus_valid) begin
        if (rdy_cnt == 0) begin
          bus_if.bus_ready = 1'b1;
          acc_pend = 1'b1;
          rdy_cnt = $urandom_range(0, 3);
        end else begin
          rdy_cnt--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_ready = 1'b1;
        bus_if.bus_rdata = $urandom;
      end

      if (if_req && if_done) begin
        if_req = 1'b0;
      end else if (!if_req && ($urandom_range(0, 1) == 1)) begin
        if_req = 1'b1;
        if_addr = 32'($urandom_range(0, 1023)) << 2;
      end
      if ((mem_req && mem_done) || !mem_req) begin
        mem_req = ($urandom_range(0, 3) != 0);
        mem_we = 1'($urandom_range(0, 1));
        mem_be = 4'($urandom);
        mem_addr = 32'h0001_0000 | (32'($urandom_range(0, 1023)) << 2);
        mem_wdata = $urandom;
      end
    end
    n_chk++; if (completions < 100) $display("FAIL rnd_progress completions=%0d exp>=100", completions); else n_pass++;
    if_req = 1'b0; mem_req = 1'b0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0;
  endtask

  initial begin
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.bus_rdata  = '0;
    last_if_rdata     = '0;
    test_reset();
    test_if_fetch();
    test_priority();
    test_starvation();
    test_flush();
    test_stalled_store();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: the maximum number of consecutive MEM grants made while IF is waiting.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-high reset (1 = reset).
REQ-004 SHALL have ports if_req in 1, if_addr in 32: the fetch request, held by the requester until if_done.
REQ-005 SHALL have ports if_rdata out 32, if_done out 1: the fetch word and a one-cycle completion pulse.
REQ-006 SHALL have ports mem_req in 1, mem_we in 1, mem_be in 4, mem_addr in 32, mem_wdata in 32: the load/store request, held until mem_done.
REQ-007 SHALL have ports mem_rdata out 32, mem_done out 1: the load data and a one-cycle completion pulse.
REQ-008 SHALL have port flush  in  1  branch_taken; cancels the current or pending fetch.
REQ-009 SHALL have ports bus_valid out 1, bus_ready in 1, bus_addr out 32, bus_we out 1, bus_be out 4, bus_wdata out 32: the shared memory request channel.
REQ-010 SHALL have ports bus_rvalid in 1, bus_rdata in 32: the response channel; one response per accepted request, writes included, arriving no earlier than the cycle after acceptance.
REQ-011 SHALL have ports if_stall out 1, mem_stall out 1: stall requests to the hazard unit.

Function
REQ-012 SHALL implement the states IDLE, ADDR, RESP and DONE.
REQ-013 In IDLE, SHALL grant MEM when mem_req=1 and (if_req=0 or starve_cnt<STARVE_MAX).
REQ-014 Otherwise in IDLE, SHALL grant IF when if_req=1 and flush=0; on any grant, go to ADDR.
REQ-015 On grant, SHALL register the source, addr, we, be and wdata; IF grants force we=0 and be=4'hF.
REQ-016 SHALL drive bus_* only from those registers; bus_valid=1 only in ADDR.
REQ-017 SHALL hold bus_valid and all bus_* values stable in ADDR until bus_ready=1, then go to RESP.
REQ-018 In RESP, on bus_rvalid=1, SHALL capture bus_rdata into the rdata register of the granted source and go to DONE.
REQ-019 In DONE, SHALL pulse exactly one of if_done or mem_done for one cycle (unless dropped per REQ-021), make no grant, and go to IDLE.
REQ-020 Minimum latency SHALL be: request at cycle 0, bus_valid at cycle 1, rvalid at cycle 2, done at cycle 3.
REQ-021 When flush=1 while an IF grant is in ADDR or RESP, SHALL set the drop flag; the bus handshake still completes, and DONE then suppresses if_done.
REQ-022 flush SHALL have no effect on MEM transactions.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) on each MEM grant made while if_req=1, and clear on every IF grant.
REQ-024 SHALL set if_stall = if_req & ~if_done and mem_stall = mem_req & ~mem_done, both combinational.
REQ-025 SHALL ignore bus_rvalid outside RESP and bus_ready outside ADDR.
REQ-026 if_rdata and mem_rdata SHALL hold their last captured value until the next capture for the same source.

Reset
REQ-027 When rst_n=1 at a clock edge, SHALL set: state=IDLE, drop=0, starve_cnt=0, bus_valid=0, if_done=0, mem_done=0, if_rdata=0, mem_rdata=0, all bus_* registers=0.
REQ-028 Reset mid-transaction SHALL abandon that transaction with no done pulse; a bus response arriving after reset is ignored per REQ-025.

Structure
REQ-029 SHALL place arb_state_t (IDLE/ADDR/RESP/DONE) and arb_src_t (SRC_IF/SRC_MEM) in rv32_pipeline_pkg.
REQ-030 SHALL be a single module with no sub-module; the state machine, starvation counter and registers live together.

Verification
REQ-031 Scenario: if_req, addr 0x100, with bus_ready and rvalid immediate and rdata 0x13 -> bus_valid at cycle 1, if_done and if_rdata=0x13 at cycle 3, if_stall high in cycles 0-2.
REQ-032 Scenario: if_req and mem_req (load, 0x2000) together -> MEM granted first; IF is granted in the IDLE cycle after mem_done.
REQ-033 Scenario: mem_req held continuously with if_req high and STARVE_MAX=4 -> after 4 MEM grants the 5th grant goes to IF.
REQ-034 Scenario: flush during IF RESP -> rvalid is consumed, no if_done, if_rdata unchanged, and the next grant proceeds normally.
REQ-035 Scenario: bus_ready low for 3 cycles on a store (be=4'b0011, wdata 0xBEEF) -> bus_* stable across all 3 cycles and mem_done 2 cycles after ready.
REQ-036 Scenario: rst_n pulsed during ADDR -> next cycle state=IDLE, bus_valid=0, no done pulse, and a late rvalid is ignored.
